// File: rtl/controle_ciclo.sv
// Washing-machine cycle sequencer with power-loss freeze and resume from a saved cycle code.
// Optional door sensor (porta_aberta) is compiled in when PORTA_SENSOR_EN is defined.
module controle_ciclo #(
  parameter int CNT_W        = 16,
  parameter int T_LAVAR      = 1000,
  parameter int T_ENXAGUE    = 600,
  parameter int T_CENTRIF    = 800,
  parameter int T_ENCHER_MAX = 500,
  parameter int T_FIM        = 50
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       energia,
  input  logic       start,
  input  logic       nivel_cheio,
  input  logic       nivel_vazio,
  input  logic [3:0] estado_restaurado,
`ifdef PORTA_SENSOR_EN
  input  logic       porta_aberta,
`endif
  output logic [3:0] estado,
  output logic       valvula_agua,
  output logic       motor_lavar,
  output logic       bomba,
  output logic       motor_centrifuga,
  output logic       porta_travada,
  output logic       fim,
  output logic       erro
);

  typedef enum logic [3:0] {
    IDLE         = 4'd0,
    ENCHER       = 4'd1,
    LAVAR        = 4'd2,
    ESVAZIAR     = 4'd3,
    ENCHER_ENX   = 4'd4,
    ENXAGUAR     = 4'd5,
    ESVAZIAR_ENX = 4'd6,
    CENTRIFUGAR  = 4'd7,
    FIM          = 4'd8,
    ERRO         = 4'd10
  } estado_e;

  localparam logic [CNT_W-1:0] LAVAR_ULT     = CNT_W'(T_LAVAR - 1);
  localparam logic [CNT_W-1:0] ENXAGUE_ULT   = CNT_W'(T_ENXAGUE - 1);
  localparam logic [CNT_W-1:0] CENTRIF_ULT   = CNT_W'(T_CENTRIF - 1);
  localparam logic [CNT_W-1:0] ENCHER_ULT    = CNT_W'(T_ENCHER_MAX - 1);
  localparam logic [CNT_W-1:0] FIM_ULT       = CNT_W'(T_FIM - 1);
  localparam logic [CNT_W-1:0] TIMER_MAX     = {CNT_W{1'b1}};

  estado_e          estado_q, estado_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic             energia_q;
  logic             retornoEnergia;
  logic             startValido;
  logic             portaFalha;

  assign retornoEnergia = energia & ~energia_q;

`ifdef PORTA_SENSOR_EN
  assign startValido = start & ~porta_aberta;
  assign portaFalha  = porta_aberta & (estado_q >= ENCHER) & (estado_q <= CENTRIFUGAR);
`else
  assign startValido = start;
  assign portaFalha  = 1'b0;
`endif

  // Codes 0 and 8 mean nothing was in progress; anything unexpected is treated as a fault.
  function automatic estado_e restaura(input logic [3:0] codigo);
    estado_e r;
    case (codigo)
      4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7: r = estado_e'(codigo);
      4'd0, 4'd8:                               r = IDLE;
      default:                                  r = ERRO;
    endcase
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      estado_q  <= IDLE;
      timer_q   <= '0;
      energia_q <= 1'b0;
    end else begin
      estado_q  <= estado_d;
      timer_q   <= timer_d;
      energia_q <= energia;
    end
  end

  // Without mains everything freezes; on the first powered cycle the saved code is reloaded.
  always_comb begin
    estado_d = estado_q;
    timer_d  = timer_q;
    if (energia) begin
      if (retornoEnergia) begin
        estado_d = restaura(estado_restaurado);
        timer_d  = '0;
      end else begin
        case (estado_q)
          IDLE:         if (startValido) estado_d = ENCHER;
          ENCHER:       if (nivel_cheio) estado_d = LAVAR;
                        else if (timer_q == ENCHER_ULT) estado_d = ERRO;
          LAVAR:        if (timer_q == LAVAR_ULT) estado_d = ESVAZIAR;
          ESVAZIAR:     if (nivel_vazio) estado_d = ENCHER_ENX;
                        else if (timer_q == ENCHER_ULT) estado_d = ERRO;
          ENCHER_ENX:   if (nivel_cheio) estado_d = ENXAGUAR;
                        else if (timer_q == ENCHER_ULT) estado_d = ERRO;
          ENXAGUAR:     if (timer_q == ENXAGUE_ULT) estado_d = ESVAZIAR_ENX;
          ESVAZIAR_ENX: if (nivel_vazio) estado_d = CENTRIFUGAR;
                        else if (timer_q == ENCHER_ULT) estado_d = ERRO;
          CENTRIFUGAR:  if (timer_q == CENTRIF_ULT) estado_d = FIM;
          FIM:          if (timer_q == FIM_ULT) estado_d = IDLE;
          default:      estado_d = ERRO;
        endcase
        if (portaFalha) estado_d = ERRO;
        if (estado_d != estado_q) timer_d = '0;
        else if (timer_q != TIMER_MAX) timer_d = timer_q + CNT_W'(1);
      end
    end
  end

  // Actuators are cut immediately on power loss; status outputs keep showing the frozen state.
  always_comb begin
    estado           = estado_q;
    valvula_agua     = energia & ((estado_q == ENCHER) | (estado_q == ENCHER_ENX));
    motor_lavar      = energia & ((estado_q == LAVAR) | (estado_q == ENXAGUAR));
    bomba            = energia & ((estado_q == ESVAZIAR) | (estado_q == ESVAZIAR_ENX) |
                                  (estado_q == CENTRIFUGAR));
    motor_centrifuga = energia & (estado_q == CENTRIFUGAR);
    porta_travada    = (estado_q >= ENCHER) & (estado_q <= CENTRIFUGAR);
    fim              = (estado_q == FIM);
    erro             = (estado_q == ERRO);
  end

endmodule

// File: tb/tb_controle_ciclo.sv
// Bench for controle_ciclo: directed scenarios with literal expectations plus a random run
// compared every cycle against a phase-level behavioural model.
module tb_controle_ciclo;

  localparam int TL = 4;
  localparam int TE = 3;
  localparam int TC = 5;
  localparam int TM = 10;
  localparam int TF = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       energia;
  logic       start;
  logic       nivel_cheio;
  logic       nivel_vazio;
  logic [3:0] estado_restaurado;
  logic [3:0] estado;
  logic       valvula_agua, motor_lavar, bomba, motor_centrifuga;
  logic       porta_travada, fim, erro;
  logic [10:0] dutVec;

  int testsRun    = 0;
  int testsFailed = 0;
  int mState      = 0;
  int mElapsed    = 0;
  bit mPrevPower  = 1'b0;
  bit checkEn     = 1'b0;

  always #5 clk = ~clk;

  controle_ciclo #(
    .CNT_W(16), .T_LAVAR(TL), .T_ENXAGUE(TE), .T_CENTRIF(TC),
    .T_ENCHER_MAX(TM), .T_FIM(TF)
  ) dut (
    .clk(clk), .reset(reset), .energia(energia), .start(start),
    .nivel_cheio(nivel_cheio), .nivel_vazio(nivel_vazio),
    .estado_restaurado(estado_restaurado), .estado(estado),
    .valvula_agua(valvula_agua), .motor_lavar(motor_lavar), .bomba(bomba),
    .motor_centrifuga(motor_centrifuga), .porta_travada(porta_travada),
    .fim(fim), .erro(erro)
  );

  assign dutVec = {estado, valvula_agua, motor_lavar, bomba, motor_centrifuga,
                   porta_travada, fim, erro};

  function automatic int restoreMap(input logic [3:0] c);
    if (c >= 4'd1 && c <= 4'd7) return int'(c);
    if (c == 4'd0 || c == 4'd8) return 0;
    return 10;
  endfunction

  function automatic int phaseLen(input int s);
    case (s)
      2: return TL;
      5: return TE;
      7: return TC;
      8: return TF;
      default: return 0;
    endcase
  endfunction

  function automatic logic [10:0] expOut(input int s, input logic pw);
    logic v, l, b, c, p, f, e;
    v = pw && (s == 1 || s == 4);
    l = pw && (s == 2 || s == 5);
    b = pw && (s == 3 || s == 6 || s == 7);
    c = pw && (s == 7);
    p = (s >= 1 && s <= 7);
    f = (s == 8);
    e = (s == 10);
    return {4'(s), v, l, b, c, p, f, e};
  endfunction

  // Phase-level model: fills/drains wait on their sensor, timed phases last their full length.
  always @(posedge clk) begin
    int nxt;
    if (reset) begin
      mState = 0; mElapsed = 0; mPrevPower = 1'b0;
    end else begin
      if (energia) begin
        if (!mPrevPower) begin
          mState = restoreMap(estado_restaurado); mElapsed = 0;
        end else begin
          nxt = mState;
          if (mState == 0) begin
            if (start) nxt = 1;
          end else if (mState == 1 || mState == 4) begin
            if (nivel_cheio) nxt = mState + 1;
            else if (mElapsed == TM - 1) nxt = 10;
          end else if (mState == 3 || mState == 6) begin
            if (nivel_vazio) nxt = mState + 1;
            else if (mElapsed == TM - 1) nxt = 10;
          end else if (phaseLen(mState) > 0 && mElapsed == phaseLen(mState) - 1) begin
            nxt = (mState == 8) ? 0 : mState + 1;
          end
          if (nxt != mState) begin mState = nxt; mElapsed = 0; end
          else mElapsed++;
        end
      end
      mPrevPower = energia;
    end
  end

  task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  always @(negedge clk) begin
    if (checkEn) checkOutput("model", {5'b0, dutVec}, {5'b0, expOut(mState, energia)});
  end

  task automatic stepEdge();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input bit rst, input bit pw, input bit st, input bit ch,
                               input bit vz, input logic [3:0] rest);
    reset = rst; energia = pw; start = st;
    nivel_cheio = ch; nivel_vazio = vz; estado_restaurado = rest;
    @(negedge clk);
  endtask

  task automatic doReset();
    stepEdge(); applyStimulus(1, 1, 0, 0, 0, 4'd0);
    checkEn = 1'b1;
    stepEdge(); applyStimulus(1, 1, 0, 0, 0, 4'd0);
    stepEdge(); applyStimulus(0, 1, 0, 0, 0, 4'd0);
    checkOutput("reset_state", {5'b0, dutVec}, 16'h0);
  endtask

  task automatic runFullCycle();
    int trace[$];
    int expTrace[10] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 0};
    int lavarCnt = 0;
    int fimCnt = 0;
    int last = -1;
    for (int i = 0; i < 60; i++) begin
      stepEdge();
      applyStimulus(0, 1, i == 0, (mState == 1 || mState == 4) && mElapsed >= 2,
                    (mState == 3 || mState == 6) && mElapsed >= 1, 4'd0);
      if (int'(estado) != last) begin trace.push_back(int'(estado)); last = int'(estado); end
      if (estado == 4'd2) lavarCnt++;
      if (fim) fimCnt++;
      if (trace.size() == 10) break;
    end
    checkOutput("full_trace_len", 16'(trace.size()), 16'd10);
    for (int i = 0; i < 10; i++)
      checkOutput("full_trace_step", (i < trace.size()) ? 16'(trace[i]) : 16'hffff, 16'(expTrace[i]));
    checkOutput("lavar_cycles", 16'(lavarCnt), 16'd4);
    checkOutput("fim_cycles", 16'(fimCnt), 16'd2);
  endtask

  task automatic runFillTimeout();
    int encherCnt = 0;
    for (int i = 0; i < 40; i++) begin
      stepEdge(); applyStimulus(0, 1, i == 0, 0, 0, 4'd0);
      if (estado == 4'd1) encherCnt++;
      if (estado == 4'd10) break;
    end
    checkOutput("timeout_cycles", 16'(encherCnt), 16'd10);
    checkOutput("timeout_erro", {15'b0, erro}, 16'd1);
    for (int i = 0; i < 15; i++) begin
      stepEdge(); applyStimulus(0, 1, 1, 1, 1, 4'd0);
    end
    checkOutput("erro_sticky", {12'b0, estado}, 16'd10);
    checkOutput("model_erro", 16'(mState), 16'd10);
  endtask

  task automatic runPowerLoss();
    int lossLeft = 0;
    bit lost = 1'b0;
    bit returned = 1'b0;
    int lavarAfter = 0;
    bit firstLoss;
    for (int i = 0; i < 60; i++) begin
      stepEdge();
      firstLoss = 1'b0;
      if (!lost && mState == 2 && mElapsed == 2) begin
        lost = 1'b1; lossLeft = 5; firstLoss = 1'b1;
      end
      applyStimulus(0, lossLeft == 0, i == 0, mState == 1 && mElapsed >= 2, 0, 4'd2);
      if (firstLoss) begin
        checkOutput("loss_motor_off", {15'b0, motor_lavar}, 16'd0);
        checkOutput("loss_estado", {12'b0, estado}, 16'd2);
        checkOutput("loss_porta", {15'b0, porta_travada}, 16'd1);
      end
      if (returned && estado == 4'd2) lavarAfter++;
      if (returned && estado == 4'd3) break;
      if (lost && lossLeft == 0) returned = 1'b1;
      if (lossLeft > 0) lossLeft--;
    end
    checkOutput("lavar_after_return", 16'(lavarAfter), 16'd4);
  endtask

  task automatic restoreWith(input logic [3:0] code);
    stepEdge(); applyStimulus(0, 0, 0, 0, 0, code);
    stepEdge(); applyStimulus(0, 1, 0, 0, 0, code);
    stepEdge(); applyStimulus(0, 1, 0, 0, 0, code);
  endtask

  task automatic runRestoreAndReset();
    doReset();
    restoreWith(4'd8);
    checkOutput("restore8", {12'b0, estado}, 16'd0);
    checkOutput("model_restore8", 16'(mState), 16'd0);
    restoreWith(4'd12);
    checkOutput("restore12", {12'b0, estado}, 16'd10);
    checkOutput("restore12_erro", {15'b0, erro}, 16'd1);
    doReset();
    restoreWith(4'd7);
    checkOutput("restore7", {5'b0, dutVec}, {5'b0, 4'd7, 7'b0011100});
    stepEdge(); applyStimulus(1, 1, 0, 0, 0, 4'd0);
    stepEdge(); applyStimulus(0, 1, 0, 0, 0, 4'd0);
    checkOutput("reset_mid_spin", {5'b0, dutVec}, 16'h0);
    stepEdge(); applyStimulus(0, 1, 0, 0, 0, 4'd0);
    stepEdge(); applyStimulus(0, 0, 1, 0, 0, 4'd0);
    stepEdge(); applyStimulus(0, 1, 0, 0, 0, 4'd0);
    checkOutput("start_no_power", {12'b0, estado}, 16'd0);
  endtask

  task automatic runRandom();
    bit rst, pw, st, ch, vz;
    logic [3:0] rest;
    for (int i = 0; i < 3000; i++) begin
      stepEdge();
      rst = ($urandom_range(0, 99) == 0);
      pw  = ($urandom_range(0, 9) != 0);
      st  = ($urandom_range(0, 3) == 0);
      ch  = ($urandom_range(0, 4) == 0);
      vz  = ($urandom_range(0, 4) == 0);
      rest = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 8));
      applyStimulus(rst, pw, st, ch, vz, rest);
    end
  endtask

  initial begin
    reset = 1'b1; energia = 1'b0; start = 1'b0;
    nivel_cheio = 1'b0; nivel_vazio = 1'b0; estado_restaurado = 4'd0;
    doReset();
    runFullCycle();
    doReset();
    runFillTimeout();
    doReset();
    runPowerLoss();
    runRestoreAndReset();
    doReset();
    runRandom();
    checkEn = 1'b0;
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
